// File: rtl/instr_fetch_ctrl.sv
// Fetch-stage controller: drives the instruction memory address, captures the
// returned word one cycle later and queues it with its PC in a 2-entry FIFO.
module instr_fetch_ctrl #(
  parameter int unsigned                PROG_CTR_WID = 8,
  parameter logic [PROG_CTR_WID-1:0]    RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  input  logic [15:0]             instr_mem_out,
  output logic [15:0]             instr_out,
  output logic [PROG_CTR_WID-1:0] instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    branch_taken,
  input  logic [PROG_CTR_WID-1:0] branch_target,
  input  logic                    halt
);

  localparam int unsigned INSTR_WID = 16;

  logic                    inflight, inflight_d;
  logic [PROG_CTR_WID-1:0] inflight_pc, inflight_pc_d;
  logic [PROG_CTR_WID-1:0] prog_ctr_d;
  logic [INSTR_WID-1:0]    tail_data, tail_data_d, head_data_d;
  logic [PROG_CTR_WID-1:0] tail_pc, tail_pc_d, head_pc_d;
  logic                    tail_valid, tail_valid_d, head_valid_d;

  logic       pop_c, push_c, issue_c;
  logic [2:0] occupancy_c;

  // Head entry of the FIFO is the output register set itself.
  assign pop_c       = instr_valid && instr_ready;
  assign push_c      = inflight && !branch_taken;
  assign occupancy_c = 3'(instr_valid) + 3'(tail_valid) + 3'(inflight);
  assign issue_c     = !halt && !branch_taken && (occupancy_c < (3'd2 + 3'(pop_c)));

  // Fetch address and in-flight tracking.
  always_comb begin
    prog_ctr_d    = prog_ctr;
    inflight_d    = issue_c;
    inflight_pc_d = inflight_pc;
    if (branch_taken) begin
      prog_ctr_d = branch_target;
    end else if (issue_c) begin
      prog_ctr_d    = prog_ctr + PROG_CTR_WID'(1);
      inflight_pc_d = prog_ctr;
    end
  end

  // FIFO update: pop shifts tail to head, push fills the first free slot.
  always_comb begin
    head_data_d  = instr_out;
    head_pc_d    = instr_pc;
    head_valid_d = instr_valid;
    tail_data_d  = tail_data;
    tail_pc_d    = tail_pc;
    tail_valid_d = tail_valid;
    if (branch_taken) begin
      head_valid_d = 1'b0;
      tail_valid_d = 1'b0;
    end else begin
      if (pop_c) begin
        if (tail_valid) begin
          head_data_d = tail_data;
          head_pc_d   = tail_pc;
        end
        head_valid_d = tail_valid;
        tail_valid_d = 1'b0;
      end
      if (push_c) begin
        if (!head_valid_d) begin
          head_data_d  = instr_mem_out;
          head_pc_d    = inflight_pc;
          head_valid_d = 1'b1;
        end else begin
          tail_data_d  = instr_mem_out;
          tail_pc_d    = inflight_pc;
          tail_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_ctr    <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      tail_data   <= '0;
      tail_pc     <= '0;
      tail_valid  <= 1'b0;
    end else begin
      prog_ctr    <= prog_ctr_d;
      inflight    <= inflight_d;
      inflight_pc <= inflight_pc_d;
      instr_out   <= head_data_d;
      instr_pc    <= head_pc_d;
      instr_valid <= head_valid_d;
      tail_data   <= tail_data_d;
      tail_pc     <= tail_pc_d;
      tail_valid  <= tail_valid_d;
    end
  end

  // Issue accounting must never let a returning word hit a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && tail_valid && !pop_c))
    else $error("instr_fetch_ctrl fifo overflow");

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed stimulus with a queue-based scoreboard
// for the 8-bit instance and a sequential model for a 4-bit free-running one.
module tb_instr_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  prog_ctr, instr_pc, branch_target;
  logic [15:0] mem_out, instr_out;
  logic        instr_valid, instr_ready, branch_taken, halt;

  logic [3:0]  pc4, ipc4;
  logic [15:0] mem4, iout4;
  logic        valid4;

  instr_fetch_ctrl #(.PROG_CTR_WID(8), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .prog_ctr(prog_ctr), .instr_mem_out(mem_out),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt)
  );

  instr_fetch_ctrl #(.PROG_CTR_WID(4), .RESET_VECTOR(4'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .prog_ctr(pc4), .instr_mem_out(mem4),
    .instr_out(iout4), .instr_pc(ipc4), .instr_valid(valid4),
    .instr_ready(1'b1), .branch_taken(1'b0), .branch_target(4'h0), .halt(1'b0)
  );

  // Instruction memories: one-cycle read latency, mem[i] = base + i.
  always @(posedge clk) begin
    mem_out <= 16'(16'hA000 + 16'(prog_ctr));
    mem4    <= 16'(16'hB000 + 16'(pc4));
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_push(input int first, input int n);
    for (int i = 0; i < n; i++)
      sb.push_back({8'(first + i), 16'(32'hA000 + first + i)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted word must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: unexpected pc %0h data %0h", instr_pc, instr_out);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(e.pc));
        chk("sb_data", 32'(instr_out), 32'(e.data));
      end
    end
  end

  // Narrow instance: PC must count 0..F and wrap with matching data.
  logic [3:0] exp4;
  int         wraps4 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp4 = 4'h0;
    end else if (valid4) begin
      chk("w4_pc", 32'(ipc4), 32'(exp4));
      chk("w4_data", 32'(iout4), 32'(16'hB000 + 16'(exp4)));
      if (exp4 == 4'hF) wraps4++;
      exp4 = exp4 + 4'd1;
    end
  end

  initial begin
    rst_n = 1'b0; instr_ready = 1'b1; halt = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00;
    repeat (3) step();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(prog_ctr), 32'h00);
    chk("rst_ipc", 32'(instr_pc), 32'h00);
    chk("rst_iout", 32'(instr_out), 32'h0000);

    // Phase A: fill, stall with ready low, then branch while full.
    exp_push(0, 4);
    rst_n = 1'b1;                                       // cycle 0
    step(); chk("valid_c1", 32'(instr_valid), 32'd0);   // cycle 1
    step(); chk("valid_c2", 32'(instr_valid), 32'd1);   // cycle 2
    chk("pc_c2", 32'(instr_pc), 32'h00);
    step(); instr_ready = 1'b0;                         // cycle 3
    for (int k = 4; k <= 7; k++) begin
      step();
      chk("stall_prog_ctr", 32'(prog_ctr), 32'h03);
      chk("stall_head", 32'(instr_pc), 32'h01);
    end
    step(); instr_ready = 1'b1;                         // cycle 8
    step(); step();                                     // cycles 9, 10
    step(); instr_ready = 1'b0;                         // cycle 11
    step();                                             // cycle 12
    step();                                             // cycle 13 = B
    chk("pre_branch_head", 32'(instr_pc), 32'h04);
    chk("pre_branch_prog_ctr", 32'(prog_ctr), 32'h06);
    branch_taken = 1'b1; branch_target = 8'h40;
    step();                                             // cycle 14 = B+1
    branch_taken = 1'b0; instr_ready = 1'b1;
    chk("drain_a", 32'(sb.size()), 32'd0);
    chk("branch_prog_ctr", 32'(prog_ctr), 32'h40);
    chk("branch_flush", 32'(instr_valid), 32'd0);
    exp_push(8'h40, 6);
    step(); chk("valid_b2", 32'(instr_valid), 32'd0);   // cycle 15
    step(); chk("valid_b3", 32'(instr_valid), 32'd1);   // cycle 16
    chk("pc_b3", 32'(instr_pc), 32'h40);

    // Halt for cycles 18..21: queued words drain, fetch stalls.
    step();                                             // cycle 17
    step(); halt = 1'b1;                                // cycle 18
    step(); chk("halt_head", 32'(instr_pc), 32'h43);    // cycle 19
    step(); chk("halt_empty", 32'(instr_valid), 32'd0); // cycle 20
    step(); chk("halt_empty2", 32'(instr_valid), 32'd0);
    chk("halt_prog_ctr", 32'(prog_ctr), 32'h44);
    step(); halt = 1'b0;                                // cycle 22
    step();                                             // cycle 23
    step(); chk("resume_pc", 32'(instr_pc), 32'h44);    // cycle 24
    step();                                             // cycle 25
    step(); instr_ready = 1'b0;                         // cycle 26
    step(); step();                                     // cycles 27, 28
    chk("full_head", 32'(instr_pc), 32'h46);
    chk("drain_b", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-cycle with the FIFO full.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_prog_ctr", 32'(prog_ctr), 32'h00);
    chk("arst_ipc", 32'(instr_pc), 32'h00);
    chk("arst_iout", 32'(instr_out), 32'h0000);
    chk("arst_valid4", 32'(valid4), 32'd0);
    sb.delete();
    step(); step();

    // Phase C: restart behaves like the first run.
    exp_push(0, 10);
    rst_n = 1'b1; instr_ready = 1'b1;                   // cycle 0
    step(); chk("re_valid_c1", 32'(instr_valid), 32'd0);
    step(); chk("re_valid_c2", 32'(instr_valid), 32'd1);
    chk("re_pc_c2", 32'(instr_pc), 32'h00);
    chk("re_data_c2", 32'(instr_out), 32'hA000);
    repeat (9) step();                                  // cycle 11
    step(); instr_ready = 1'b0;                         // cycle 12
    step();
    chk("drain_c", 32'(sb.size()), 32'd0);
    chk("w4_wrapped", 32'(wraps4 > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
